// File: rtl/dnn_pkg.sv
// Shared types for the dnn inference-core scheduler.
// Activation vector layout and scheduler FSM encoding.
package dnn_pkg;

    localparam int X_W   = 7;
    localparam int OUT_W = 21;
    localparam int NX    = 4;

    typedef logic signed [NX-1:0][X_W-1:0] dnn_x_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

endpackage

// File: rtl/dnn_sched_if.sv
// Requester, core and response signals of the dnn scheduler.
// master = scheduler side, slave = environment side.
interface dnn_sched_if #(
    parameter int NUM_REQ = 4
);
    import dnn_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*NX*X_W-1:0]  req_x;

    logic signed [X_W-1:0]      core_x0;
    logic signed [X_W-1:0]      core_x1;
    logic signed [X_W-1:0]      core_x2;
    logic signed [X_W-1:0]      core_x3;
    logic                       core_in_ready;
    logic signed [OUT_W-1:0]    core_out0;
    logic signed [OUT_W-1:0]    core_out1;
    logic                       core_out_ready;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic signed [OUT_W-1:0]    rsp_out0;
    logic signed [OUT_W-1:0]    rsp_out1;
    logic                       rsp_err;
    logic                       busy;

    modport master (
        input  req_valid, req_x,
        input  core_out0, core_out1, core_out_ready,
        input  rsp_ready,
        output req_ready,
        output core_x0, core_x1, core_x2, core_x3, core_in_ready,
        output rsp_valid, rsp_id, rsp_out0, rsp_out1, rsp_err,
        output busy
    );

    modport slave (
        output req_valid, req_x,
        output core_out0, core_out1, core_out_ready,
        output rsp_ready,
        input  req_ready,
        input  core_x0, core_x1, core_x2, core_x3, core_in_ready,
        input  rsp_valid, rsp_id, rsp_out0, rsp_out1, rsp_err,
        input  busy
    );

endinterface

// File: rtl/dnn_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above
// i_ptr (with wrap) wins; the pointer itself lives in the caller.
module dnn_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_k;

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_sum = '0;
        w_k   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
            w_k   = (w_sum >= (ID_W+1)'(NUM_REQ))
                  ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                  : ID_W'(w_sum);
            if (!o_any && i_req[w_k]) begin
                o_any = 1'b1;
                o_idx = w_k;
            end
        end
    end

    assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/dnn_sched.sv
// Shares one dnn core between NUM_REQ requesters, one job in flight.
// Define DNN_SCHED_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.
module dnn_sched
    import dnn_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CORE_LAT = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    dnn_sched_if.master bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int XV_W = NX * X_W;

    if (NUM_REQ < 2 || NUM_REQ > 8 || CORE_LAT < 1 || TIMEOUT < 1)
    begin : g_bad_cfg
        $error("dnn_sched: unsupported parameter set");
    end

    sched_state_t            r_state;
    logic [ID_W-1:0]         r_ptr;
    logic [ID_W-1:0]         r_job;
    dnn_x_vec_t              r_x;
    logic                    r_in_rdy;
    logic                    r_rsp_valid;
    logic [ID_W-1:0]         r_rsp_id;
    logic signed [OUT_W-1:0] r_out0;
    logic signed [OUT_W-1:0] r_out1;

    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_W-1:0]         w_idx;
    logic [ID_W-1:0]         w_ptr_nxt;
    logic                    w_any;
    logic                    w_buf_free;
    logic                    w_xfer;
    dnn_x_vec_t              w_x_sel;

    dnn_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A grant needs the response slot free, possibly by a same-cycle pop
    assign w_buf_free = !r_rsp_valid || bus.rsp_ready;
    assign w_xfer     = !rst && (r_state == IDLE) && w_buf_free && w_any;
    assign w_x_sel    = bus.req_x[int'(w_idx)*XV_W +: XV_W];
    assign w_ptr_nxt  = (int'(w_idx) == NUM_REQ-1) ? '0 : w_idx + 1'b1;

`ifdef DNN_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_tmo;
    assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign bus.rsp_err = r_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_job       <= '0;
            r_x         <= '0;
            r_in_rdy    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_out0      <= '0;
            r_out1      <= '0;
`ifdef DNN_SCHED_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_in_rdy <= 1'b0;
            if (r_rsp_valid && bus.rsp_ready)
                r_rsp_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_x      <= w_x_sel;
                        r_job    <= w_idx;
                        r_ptr    <= w_ptr_nxt;
                        r_in_rdy <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef DNN_SCHED_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
`ifdef DNN_SCHED_TIMEOUT_EN
                    r_cnt <= r_cnt + 1'b1;
`endif
                    if (bus.core_out_ready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_job;
                        r_out0      <= bus.core_out0;
                        r_out1      <= bus.core_out1;
`ifdef DNN_SCHED_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        r_state     <= IDLE;
                    end
`ifdef DNN_SCHED_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_job;
                        r_out0      <= '0;
                        r_out1      <= '0;
                        r_err       <= 1'b1;
                        r_state     <= IDLE;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = w_xfer ? w_grant : '0;
    assign bus.core_x0       = r_x[0];
    assign bus.core_x1       = r_x[1];
    assign bus.core_x2       = r_x[2];
    assign bus.core_x3       = r_x[3];
    assign bus.core_in_ready = r_in_rdy;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_rsp_id;
    assign bus.rsp_out0      = r_out0;
    assign bus.rsp_out1      = r_out1;
    assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_dnn_sched.sv
// Directed bench for dnn_sched with a fixed-latency core model.
// Timeout vectors are built only with DNN_SCHED_TIMEOUT_EN.
module tb_dnn_sched;
    import dnn_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int CORE_LAT = 4;
    localparam int TIMEOUT  = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dnn_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    dnn_sched #(
        .NUM_REQ  (NUM_REQ),
        .CORE_LAT (CORE_LAT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic                    m_en    = 1'b1;
    logic                    m_rdy   = 1'b0;
    logic                    m_stray = 1'b0;
    logic signed [OUT_W-1:0] m_o0    = '0;
    logic signed [OUT_W-1:0] m_o1    = '0;
    logic signed [OUT_W-1:0] m_s0    = '0;

    assign bus.core_out_ready = m_rdy | m_stray;
    assign bus.core_out0      = m_stray ? m_s0 : m_o0;
    assign bus.core_out1      = m_stray ? m_s0 : m_o1;

    // Core answers CORE_LAT cycles after the cycle core_in_ready is high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.core_in_ready === 1'b1 && m_en) begin
                repeat (CORE_LAT) @(posedge clk);
                #1 m_rdy = 1'b1;
                @(posedge clk);
                #1 m_rdy = 1'b0;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_x(input int r, input int x3, input int x2,
                         input int x1, input int x0);
        bus.req_x[r*NX*X_W +: NX*X_W] = {7'(x3), 7'(x2), 7'(x1), 7'(x0)};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int g_vec[5];
    int g_cyc[5];
    int ng;
    int bad;
    int lat;
    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        bus.req_x     = '0;

        // reset state, with all requests asserted
        tick();
        tick();
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_in_ready", 32'(bus.core_in_ready), 0);
        chk("rst_x0", 32'(bus.core_x0), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_out0", 32'(bus.rsp_out0), 0);
        chk("rst_err", 32'(bus.rsp_err), 0);
        rst = 1'b0;
        bus.req_valid = '0;

        // single job from requester 2
        put_x(2, 3, -2, 5, 1);
        m_o0 = 100;
        m_o1 = -7;
        bus.req_valid = 4'b0100;
        #1;
        chk("s_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        #1;
        chk("s_in_ready", 32'(bus.core_in_ready), 1);
        chk("s_busy", 32'(bus.busy), 1);
        chk("s_x0", 32'(bus.core_x0), 1);
        chk("s_x1", 32'(bus.core_x1), 5);
        chk("s_x2", 32'(bus.core_x2), -2);
        chk("s_x3", 32'(bus.core_x3), 3);
        tick();
        #1;
        chk("s_in_ready_pulse", 32'(bus.core_in_ready), 0);
        tick();
        tick();
        tick();
        #1;
        chk("s_rsp_early", 32'(bus.rsp_valid), 0);
        tick();
        #1;
        chk("s_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("s_rsp_id", 32'(bus.rsp_id), 2);
        chk("s_out0", 32'(bus.rsp_out0), 100);
        chk("s_out1", 32'(bus.rsp_out1), -7);
        chk("s_err", 32'(bus.rsp_err), 0);
        chk("s_idle", 32'(bus.busy), 0);
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        chk("s_pop", 32'(bus.rsp_valid), 0);

        // round robin with all requesters active
        do_reset();
        m_o0 = 1;
        m_o1 = 2;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        ng = 0;
        for (int i = 0; i < 5; i++) begin
            g_vec[i] = 0;
            g_cyc[i] = 0;
        end
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                g_vec[ng] = 32'(bus.req_ready);
                g_cyc[ng] = c;
                ng++;
            end
            tick();
        end
        bus.req_valid = '0;
        chk("rr_count", ng, 5);
        for (int i = 0; i < 5; i++)
            chk("rr_grant", g_vec[i], 1 << order[i]);
        for (int i = 1; i < 5; i++)
            chk("rr_gap", g_cyc[i] - g_cyc[i-1], CORE_LAT + 2);
        repeat (8) tick();

        // backpressure on the response slot
        do_reset();
        m_o0 = 55;
        m_o1 = -3;
        bus.req_valid = 4'b0001;
        #1;
        chk("bp_grant0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0010;
        repeat (5) tick();
        #1;
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("bp_out0", 32'(bus.rsp_out0), 55);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            #1;
            if (bus.req_ready != '0 || !bus.rsp_valid ||
                bus.rsp_id != 0 || bus.rsp_out0 != 55 ||
                bus.rsp_out1 != -3)
                bad++;
        end
        chk("bp_hold", bad, 0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_pop_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        #1;
        chk("bp_popped", 32'(bus.rsp_valid), 0);
        chk("bp_issue1", 32'(bus.core_in_ready), 1);
        repeat (8) tick();

        // reset while waiting on the core
        do_reset();
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            if (bus.rsp_valid || bus.busy)
                bad++;
        end
        chk("rw_quiet", bad, 0);
        chk("rw_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rw_busy", 32'(bus.busy), 0);
        bus.req_valid = 4'b1111;
        #1;
        chk("rw_ptr", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;
        repeat (2) tick();

        // stray core strobe while idle
        do_reset();
        m_o0 = -9;
        m_o1 = 42;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        repeat (5) tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        m_s0 = 333;
        m_stray = 1'b1;
        tick();
        m_stray = 1'b0;
        #1;
        chk("st_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("st_out0", 32'(bus.rsp_out0), -9);
        chk("st_out1", 32'(bus.rsp_out1), 42);
        chk("st_id", 32'(bus.rsp_id), 2);
        chk("st_busy", 32'(bus.busy), 0);

`ifdef DNN_SCHED_TIMEOUT_EN
        // core never answers
        do_reset();
        m_en = 1'b0;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        #1;
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
            tick();
            #1;
        end
        chk("to_latency", lat, TIMEOUT + 2);
        chk("to_err", 32'(bus.rsp_err), 1);
        chk("to_out0", 32'(bus.rsp_out0), 0);
        chk("to_out1", 32'(bus.rsp_out1), 0);
        chk("to_id", 32'(bus.rsp_id), 0);
        m_en = 1'b1;
        m_o0 = 7;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1000;
        #1;
        chk("to_resume_grant", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        repeat (5) tick();
        #1;
        chk("to_resume_valid", 32'(bus.rsp_valid), 1);
        chk("to_resume_err", 32'(bus.rsp_err), 0);
        chk("to_resume_id", 32'(bus.rsp_id), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
